twos_serial_converter: RTL and testbench
========================================

Name: twos_serial_converter

Overview:
- Bit-serial two's-complement negator with valid/ready handshakes on both sides.
- Sits directly upstream of the parallel two's-complement stage as its sequential, area-minimal counterpart, and produces the same `~a + 1` result.
- Accepts a parallel word, processes it LSB-first using the "copy up to and including the first 1, then invert" rule, and presents the negated word in parallel with status flags.
- One conversion is in flight at a time.

Parameters:
- WIDTH, 4, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word; high only in IDLE and while rst is low.
- in_data  input  WIDTH  operand, two's-complement.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  negated operand, `(~in_data + 1)` mod 2^WIDTH.
- out_zero  output  1  operand was 0 (result 0).
- out_ovf  output  1  operand was -2^(WIDTH-1) (result equals operand; negation not representable).

Behaviour:
- Reset (rst high at a clk edge):
  - state <= IDLE; out_valid <= 0; out_data <= 0; out_zero <= 0; out_ovf <= 0.
  - Internal shift register, bit counter and seen_one flag are all cleared.
  - in_ready is 0 whenever rst is high.
- Reset mid-operation (in SHIFT or DONE): the word in flight is discarded and no out_valid pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1:
    - Load in_data into the shift register.
    - count <= 0; seen_one <= 0.
    - Latch out_zero = (in_data == 0).
    - Latch out_ovf = (in_data == {1'b1, {WIDTH-1{1'b0}}}).
    - Go to SHIFT.
  - With in_valid=0, stay in IDLE.
- SHIFT:
  - One bit per edge. The bit b at index count is processed as:
    - r = seen_one ? ~b : b
    - result[count] <= r
    - seen_one <= seen_one | b
    - count <= count + 1
  - in_ready = 0; in_valid is ignored.
  - On the edge that processes count == WIDTH-1, go to DONE and set out_valid <= 1 in the same edge.
- DONE:
  - out_valid = 1.
  - out_data, out_zero and out_ovf are held stable while out_ready = 0 (arbitrary backpressure).
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE.
- Latency and throughput:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - The next word can be accepted no earlier than the edge after the output handshake.
  - Minimum period is WIDTH+2 cycles per word. There is no IDLE/DONE bypass.
- out_data is registered. It keeps its last value after the handshake until the next conversion overwrites it bit by bit; downstream must only sample it when out_valid = 1.
- Flags are registered at load and change only at the next load or at reset.
- Arithmetic is mod 2^WIDTH. No carry chain: the serial rule replaces the +1.
- count width is clog2(WIDTH) bits; the rule "count == WIDTH-1 terminates" must hold for non-power-of-2 WIDTH.
- out_valid does not depend combinationally on out_ready, and in_ready does not depend combinationally on in_valid.

Decomposition:
- Shared header/package twos_defs: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
- Sub-module twos_serial_cell: the 1-bit seen_one flop plus XOR. Inputs are clk, rst, clr, en and b; output is r.
- Top level holds the FSM, counter, shift/result registers and flags.

Test Plan:
- Basic conversion (WIDTH=4): in_data=4'b0101, out_ready=1 → out_valid rises 4 edges after accept; out_data=4'b1011; out_zero=0; out_ovf=0; in_ready returns 1 one cycle after the output handshake.
- Zero input: in_data=0 → out_data=0, out_zero=1, out_ovf=0.
- Most-negative input: in_data=4'b1000 → out_data=4'b1000, out_ovf=1, out_zero=0.
- Backpressure: in_data=4'b0011, out_ready held 0 for 6 cycles after out_valid → out_valid stays 1 and out_data stays 4'b1101 throughout; in_ready stays 0; in_valid pulses meanwhile are not accepted. Release out_ready → one handshake, then IDLE.
- Exhaustive sweep: feed 0..15 back-to-back with in_valid always high and random out_ready → each out_data equals (~i+1)&4'hF, in order, with no drops or duplicates.
- Reset mid-SHIFT: accept 4'b0110, assert rst for one edge at count=2 → no out_valid pulse; all outputs 0; in_ready=1 on the cycle after rst deasserts; a following conversion of 4'b0001 gives 4'b1111.

Source files
------------

// File: rtl/twos_defs.sv
// Shared definitions for the bit-serial two's-complement negator.
package twos_defs;

   // Default operand/result width.
   localparam int DEF_WIDTH = 4;

   // Controller states; encodings are fixed so other blocks can decode them.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/twos_serial_cell.sv
// One-bit serial negation cell.
// Rule: pass bits through until the first 1 has been seen, then invert every bit after it.
// The output r is combinational. It uses the flag value from before the current bit,
// so the first 1 itself is passed through unchanged.
module twos_serial_cell
   import twos_defs::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic b,
   output logic r
);

   logic seen_one;

   // seen_one is cleared at reset or on a new word, and accumulates every processed bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         seen_one <= 1'b0;
      end else if (clr) begin
         seen_one <= 1'b0;
      end else if (en) begin
         seen_one <= seen_one | b;
      end
   end

   assign r = seen_one ^ b;

endmodule

// File: rtl/twos_serial_converter.sv
// Bit-serial two's-complement negator with valid/ready on both sides.
// Each word is processed LSB-first, one bit per cycle.
// The result builds up in place in out_data. The handshake is on the DONE state.
module twos_serial_converter
   import twos_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_ovf
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_IDX = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state, nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] sreg;
   logic             load, shift_en, last, accept_ok, r;

   // The serial rule that replaces ~x+1: the flag flop and the XOR live in the cell.
   twos_serial_cell u_cell (
      .clk (clk),
      .rst (rst),
      .clr (load),
      .en  (shift_en),
      .b   (sreg[0]),
      .r   (r)
   );

   // Next-state logic and strobes. The terminal count is an explicit compare,
   // so widths that are not a power of two work.
   always_comb begin
      nxt       = state;
      accept_ok = 1'b0;
      load      = 1'b0;
      shift_en  = 1'b0;
      last      = (count == LAST_IDX);
      case (state)
         IDLE: begin
            accept_ok = 1'b1;
            if (in_valid) begin
               load = 1'b1;
               nxt  = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (last) nxt = DONE;
         end
         DONE: begin
            if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // in_ready depends only on the state and on rst, never on in_valid.
   assign in_ready = accept_ok & ~rst;

   // State register. A reset discards any word in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Datapath: load the operand and latch the flags.
   // Then shift out one bit per cycle and write each result bit into its position.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg      <= '0;
         count     <= '0;
         out_data  <= '0;
         out_zero  <= 1'b0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (load) begin
            sreg     <= in_data;
            count    <= '0;
            out_zero <= (in_data == '0);
            out_ovf  <= (in_data == MOST_NEG);
         end
         if (shift_en) begin
            sreg            <= {1'b0, sreg[WIDTH-1:1]};
            out_data[count] <= r;
            count           <= count + 1'b1;
            if (last) out_valid <= 1'b1;
         end
         if (state == DONE && out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_twos_serial_converter.sv
// Self-checking bench for twos_serial_converter (WIDTH=4).
// Uses directed cases plus random words with random backpressure.
module tb_twos_serial_converter;

   localparam int W = 4;

   logic         clk, rst;
   logic         in_valid, in_ready, out_valid, out_ready, out_zero, out_ovf;
   logic [W-1:0] in_data, out_data;

   int checks = 0;
   int errors = 0;

   twos_serial_converter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: arithmetic negation modulo 2^W.
   function automatic logic [W-1:0] neg_ref(input int x);
      return W'((16 - (x % 16)) % 16);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction.
   // If stall > 0, out_ready is held low for that many cycles after out_valid.
   // During the stall the upstream pulses in_valid, and those pulses must be ignored.
   task automatic convert(input logic [W-1:0] x, input int stall);
      int n;
      logic [W-1:0] e;
      e = neg_ref(int'(x));
      in_valid  = 1'b1;
      in_data   = x;
      out_ready = (stall == 0);
      chk("in_ready_idle", in_ready, 1);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("latency", n, W);
      chk("out_data", out_data, e);
      chk("out_zero", out_zero, x == 0);
      chk("out_ovf", out_ovf, x == 4'b1000);
      for (int k = 0; k < stall; k++) begin
         in_valid = k[0];
         in_data  = W'($urandom);
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, e);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_hs_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
   endtask

   initial begin
      logic [W-1:0] expq[$];
      logic [W-1:0] e;
      int idx, got, cyc;
      logic acc, hs;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_flags", {out_zero, out_ovf}, 0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", in_ready, 1);

      // Directed cases: basic, zero, most-negative, and backpressure.
      convert(4'b0101, 0);
      convert(4'b0000, 0);
      convert(4'b1000, 0);
      convert(4'b0011, 6);
      // No spurious conversion after the stall pulses.
      for (int k = 0; k < W + 2; k++) begin
         tick();
         chk("idle_no_valid", out_valid, 0);
      end

      // Random words with random backpressure.
      for (int k = 0; k < 12; k++) convert(W'($urandom), int'($urandom_range(0, 4)));

      // Back-to-back sweep 0..15: in_valid stays high, out_ready is random,
      // and a scoreboard checks order.
      idx = 0; got = 0; cyc = 0;
      while (got < 16 && cyc < 2000) begin
         in_valid  = (idx < 16);
         in_data   = W'(idx);
         out_ready = 1'($urandom);
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         if (hs) begin
            e = (expq.size() > 0) ? expq.pop_front() : 'x;
            chk("sweep_data", out_data, e);
            got++;
         end
         if (acc) begin
            expq.push_back(neg_ref(idx));
            idx++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("sweep_count", got, 16);
      chk("sweep_queue_empty", expq.size(), 0);
      tick();
      tick();

      // Reset while in SHIFT with count == 2: the word is dropped and no output is produced.
      chk("pre_rst_in_ready", in_ready, 1);
      in_valid = 1'b1; in_data = 4'b0110;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mid_no_valid", out_valid, 0);
      rst = 1'b1;
      #1;
      chk("rst_high_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_flags", {out_zero, out_ovf}, 0);
      chk("midrst_in_ready", in_ready, 1);
      for (int k = 0; k < W + 2; k++) begin
         tick();
         chk("midrst_no_pulse", out_valid, 0);
      end
      convert(4'b0001, 0);
      chk("after_rst_result", out_data, 4'b1111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Bound on total run time so the bench always ends.
   initial begin
      #500000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
